// File: rtl/voxel_frame_sequencer_if.sv
// Write-path bundle: host write channels, world_gen write stream and the
// registered voxel memory write port that the sequencer arbitrates onto.
interface voxel_frame_sequencer_if #(
    parameter int NUM_WR_CH = 2,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 64
);
    logic [NUM_WR_CH-1:0]        wr_valid;
    logic [NUM_WR_CH*ADDR_W-1:0] wr_addr;
    logic [NUM_WR_CH*DATA_W-1:0] wr_data;
    logic [NUM_WR_CH-1:0]        wr_ready;
    logic                        wgen_wen;
    logic [ADDR_W-1:0]           wgen_waddr;
    logic [DATA_W-1:0]           wgen_wdata;
    logic                        wgen_stall;
    logic                        mem_wen;
    logic [ADDR_W-1:0]           mem_waddr;
    logic [DATA_W-1:0]           mem_wdata;

    // Write producers (host shell, world_gen) and the memory they land in.
    modport master (
        output wr_valid, wr_addr, wr_data, wgen_wen, wgen_waddr, wgen_wdata,
        input  wr_ready, wgen_stall, mem_wen, mem_waddr, mem_wdata
    );

    // Sequencer side: grants writes and drives the memory port.
    modport slave (
        input  wr_valid, wr_addr, wr_data, wgen_wen, wgen_waddr, wgen_wdata,
        output wr_ready, wgen_stall, mem_wen, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/voxel_frame_sequencer.sv
// Frame control: builds the world, launches raycaster frames in STOP /
// CONTINUOUS / SINGLE mode, double-buffers the camera, watches frame length,
// and merges host + world_gen writes onto one registered memory port.
module voxel_frame_sequencer #(
    parameter int NUM_WR_CH   = 2,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 64,
    parameter int CAM_W       = 128,
    parameter int FCNT_W      = 32,
    parameter int WDOG_CYCLES = 2000000,
    parameter bit HOLD_WR_RUN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  step,
    input  logic                  regen,
    output logic                  world_start,
    input  logic                  world_done,
    voxel_frame_sequencer_if.slave wr,
    input  logic                  cam_load,
    input  logic [CAM_W-1:0]      cam_in,
    output logic [CAM_W-1:0]      cam_active,
    output logic                  cam_pending,
    output logic                  core_start,
    input  logic                  core_done,
    output logic                  world_ready,
    output logic                  frame_busy,
    output logic [FCNT_W-1:0]     frame_count,
    output logic                  frame_timeout,
    output logic [2:0]            seq_state
);
    // Q8.8 home camera: pos (10,10,10), dir (1.0,0,0), plane (0,0.66).
    localparam logic [127:0] CAM_HOME = {16'h0A00, 16'h0A00, 16'h0A00, 16'h0100,
                                         16'h0000, 16'h0000, 16'h0000, 16'h00AA};
    localparam logic [CAM_W-1:0] CAM_RST = CAM_W'(CAM_HOME);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_WGEN   = 3'd1,
        S_READY  = 3'd2,
        S_LAUNCH = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [31:0]           wdog_cnt;
    logic                  wdog_expire;
    logic [CAM_W-1:0]      cam_shadow;
    logic                  host_en, host_win;
    logic [NUM_WR_CH-1:0]  grant;
    logic [ADDR_W-1:0]     host_addr;
    logic [DATA_W-1:0]     host_data;

    // Expires on the last permitted RUN cycle; a zero budget never expires.
    assign wdog_expire = (WDOG_CYCLES != 0) && (wdog_cnt == 32'(WDOG_CYCLES - 1));

    assign core_start = (state == S_LAUNCH);
    assign frame_busy = (state == S_LAUNCH) || (state == S_RUN);
    assign seq_state  = state;

    // Next-state logic; regen wins over launch, step only counts in SINGLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:   state_nx = S_WGEN;
            S_WGEN:   if (world_done) state_nx = S_READY;
            S_READY: begin
                if (regen)
                    state_nx = S_INIT;
                else if (mode == 2'd1 || (mode == 2'd2 && step))
                    state_nx = S_LAUNCH;
            end
            S_LAUNCH: state_nx = S_RUN;
            S_RUN:    if (core_done || wdog_expire) state_nx = S_READY;
            default:  state_nx = S_INIT;
        endcase
    end

    // State register plus frame bookkeeping (world flag, counter, watchdog).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_INIT;
            world_start   <= 1'b0;
            world_ready   <= 1'b0;
            frame_count   <= '0;
            frame_timeout <= 1'b0;
            wdog_cnt      <= '0;
        end else begin
            state       <= state_nx;
            world_start <= (state == S_INIT);
            if (state == S_WGEN && world_done)
                world_ready <= 1'b1;
            else if (state == S_READY && regen)
                world_ready <= 1'b0;
            if (state == S_RUN && core_done)
                frame_count <= frame_count + 1'b1;
            if (state == S_RUN && !core_done && wdog_expire)
                frame_timeout <= 1'b1;
            wdog_cnt <= (state == S_RUN) ? wdog_cnt + 32'd1 : 32'd0;
        end
    end

    // Camera double buffer; a load during LAUNCH goes straight to the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_shadow  <= CAM_RST;
            cam_active  <= CAM_RST;
            cam_pending <= 1'b0;
        end else begin
            if (cam_load)
                cam_shadow <= cam_in;
            if (state == S_LAUNCH) begin
                cam_active  <= cam_load ? cam_in : cam_shadow;
                cam_pending <= 1'b0;
            end else if (cam_load) begin
                cam_pending <= 1'b1;
            end
        end
    end

    // Fixed-priority host grant: lowest valid index wins, blocked mid-frame.
    always_comb begin
        grant     = '0;
        host_win  = 1'b0;
        host_addr = '0;
        host_data = '0;
        host_en   = !(HOLD_WR_RUN && frame_busy);
        for (int i = 0; i < NUM_WR_CH; i++) begin
            if (host_en && wr.wr_valid[i] && !host_win) begin
                grant[i]  = 1'b1;
                host_win  = 1'b1;
                host_addr = wr.wr_addr[i*ADDR_W +: ADDR_W];
                host_data = wr.wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr.wr_ready   = grant;
    assign wr.wgen_stall = wr.wgen_wen && host_win;

    // One write per cycle onto the memory port, one clock after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr.mem_wen   <= 1'b0;
            wr.mem_waddr <= '0;
            wr.mem_wdata <= '0;
        end else begin
            wr.mem_wen <= host_win || wr.wgen_wen;
            if (host_win) begin
                wr.mem_waddr <= host_addr;
                wr.mem_wdata <= host_data;
            end else if (wr.wgen_wen) begin
                wr.mem_waddr <= wr.wgen_waddr;
                wr.mem_wdata <= wr.wgen_wdata;
            end
        end
    end
endmodule
